mul_arbiter: RTL and testbench
==============================

Name: mul_arbiter

Overview:
- Shares one `seq_mult_256bit` instance (257-bit operands, 514-bit product, `start` in, `done2` out) among NREQ requesters, e.g. point-add, point-double and inversion units of the ed25519 datapath.
- Arbitrates round-robin and captures operands.
- Issues a single-cycle `start` pulse, then detects completion on the rising edge of `done2`.
- Returns the product to the owning requester; a watchdog recovers from a multiplier that never completes.

Parameters:
- NREQ, 4: number of requesters (2..8).
- W, 257: operand width (matches `b).
- PW, 514: product width (matches `b2).
- TIMEOUT, 1024: maximum number of WAIT cycles before an error response.
- CW, 11: watchdog counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- op_a  in  NREQ*W  packed operand A; slice i belongs to requester i.
- op_b  in  NREQ*W  packed operand B; slice i belongs to requester i.
- ack  out  NREQ  one-hot, one-cycle pulse: operands captured.
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: result ready for that requester.
- rsp_product  out  PW  result, valid while rsp_valid is nonzero.
- rsp_err  out  1  high with rsp_valid when the watchdog expired.
- busy  out  1  high in LAUNCH and WAIT.
- mul_a  out  W  operand A to the multiplier, registered.
- mul_b  out  W  operand B to the multiplier, registered.
- mul_start  out  1  start pulse to the multiplier.
- mul_product  in  PW  multiplier product.
- mul_done  in  1  multiplier `done2`.

Behaviour:
- Reset (asynchronous) clears:
  - state to IDLE;
  - ack, rsp_valid, rsp_err, mul_start, busy, mul_a, mul_b, rsp_product, cnt to 0;
  - done_q to 0;
  - the round-robin pointer `last` to NREQ-1, so requester 0 has first priority.
- Every output is registered.
- done_q <= mul_done on every edge.
- done_rise = mul_done & ~done_q.
- States: IDLE, LAUNCH, WAIT.
- IDLE, when any req is high at edge E0:
  - winner = first requester with req high, searching from last+1 with wrap.
  - ack[winner] <= 1; owner <= winner.
  - mul_a/mul_b <= op_a/op_b slices of the winner.
  - mul_start <= 1.
  - -> LAUNCH.
- LAUNCH (edge E1):
  - ack <= 0; mul_start <= 0; cnt <= 0.
  - last <= owner.
  - -> WAIT.
  - mul_done is ignored in this state.
- WAIT, each edge:
  - If done_rise: rsp_product <= mul_product; rsp_valid[owner] <= 1; rsp_err <= 0; -> IDLE.
  - Else if cnt == TIMEOUT-1: rsp_product <= 0; rsp_valid[owner] <= 1; rsp_err <= 1; -> IDLE.
  - Else cnt <= cnt+1.
- rsp_valid and rsp_err clear on the next edge.
- IDLE may grant a new request on the same edge that clears rsp_valid.
- Requester contract:
  - Hold req and operands stable until ack is seen.
  - Drop req on the edge after ack; a req still high in IDLE is a new request.
- mul_done high on entry to WAIT, or stuck high, does not complete an operation; only a 0->1 transition observed in WAIT does.
- Simultaneous requests: exactly one ack per grant, strictly round-robin, so no requester is starved while it holds req.
- Reset during LAUNCH or WAIT:
  - Operation is abandoned and no rsp_valid is ever issued for it.
  - The multiplier reloads on its next start, so a subsequent grant proceeds normally.
- busy = (state != IDLE).
- Best-case latency from grant edge E0 to rsp_valid: multiplier latency + 2 edges.

Decomposition:
- Shared package `ed25519_pkg` holds:
  - width constants W=257, PW=514;
  - q and l constants;
  - state encoding IDLE=2'd0, LAUNCH=2'd1, WAIT=2'd2.
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: req[NREQ], last index.
  - Outputs: winner index and any_req.
- The multiplier is instantiated one level up, not inside the arbiter.

Test Plan:
- Single op: req[0], a=3, b=5.
  - ack[0] pulses for one cycle one edge after req; mul_start pulses exactly once.
  - rsp_valid=4'b0001, rsp_product=15, rsp_err=0.
- Boundary operands: req[1], a=b=2^256.
  - rsp_product=2^512 (bit 512 set, all other bits 0).
- Contention: req[0], req[1], req[2] raised together, each held until its ack; a=i+2, b=10.
  - Grants in order 0, 1, 2; rsp_product 20, 30, 40.
  - Then req[0] and req[3] together: grant order 3, 0.
- Stale done: stub multiplier holds done2=1 from reset, then drops it and raises it 8 cycles after start.
  - Exactly one rsp_valid, 8 cycles after start plus 2; no early response.
- Watchdog: TIMEOUT=16 with a stub multiplier whose done2 never rises.
  - rsp_valid[owner]=1 and rsp_err=1 at edge E0+17; rsp_product=0; busy falls on that edge.
- Reset mid-WAIT: rst asserted during WAIT.
  - All outputs 0 asynchronously; no rsp_valid for the aborted op.
  - After release, req[2] with a=7, b=9 gives rsp_product=63 and rsp_valid=4'b0100.

Source files
------------

// File: rtl/ed25519_pkg.sv
// ed25519_pkg: shared widths, curve constants and arbiter state encoding.
package ed25519_pkg;
    localparam int W  = 257;
    localparam int PW = 514;
    localparam logic [W-1:0] Q = 257'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
    localparam logic [W-1:0] L = 257'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;
    typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2} state_t;
endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, searching upward from last_i+1 with wrap.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int LW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [LW-1:0]   last_i,
    output logic [LW-1:0]   winner_o,
    output logic            any_req_o
);
    assign any_req_o = |req_i;
    // descending scan so the nearest requester after last_i overwrites the rest
    always_comb begin
        winner_o = last_i;
        for (int k = NREQ; k >= 1; k--)
            if (req_i[LW'((int'(last_i) + k) % NREQ)]) winner_o = LW'((int'(last_i) + k) % NREQ);
    end
endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one sequential multiplier among NREQ requesters with a
// round-robin grant, done2 rising-edge completion and a watchdog error response.
module mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 257,
    parameter int PW      = 514,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    output logic [NREQ-1:0]  ack,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [PW-1:0]    rsp_product,
    output logic             rsp_err,
    output logic             busy,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    output logic             mul_start,
    input  logic [PW-1:0]    mul_product,
    input  logic             mul_done
);
    import ed25519_pkg::*;
    localparam int LW = $clog2(NREQ);
    state_t          state_q, state_d;
    logic [LW-1:0]   owner_q, owner_d, last_q, last_d, winner;
    logic            any_req, done_q, done_rise;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] ack_q, ack_d, rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d, mul_start_q, mul_start_d, busy_q;
    logic [W-1:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [PW-1:0]   rsp_product_q, rsp_product_d;

    rr_pick #(.NREQ(NREQ), .LW(LW)) u_pick (
        .req_i(req), .last_i(last_q), .winner_o(winner), .any_req_o(any_req)
    );

    // a done2 level left over from an earlier operation never completes this one
    assign done_rise = mul_done & ~done_q;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        ack_d         = '0;
        rsp_valid_d   = '0;
        rsp_err_d     = 1'b0;
        mul_start_d   = 1'b0;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        rsp_product_d = rsp_product_q;
        case (state_q)
            IDLE: if (any_req) begin
                ack_d       = NREQ'(1) << winner;
                owner_d     = winner;
                mul_a_d     = op_a[int'(winner)*W +: W];
                mul_b_d     = op_b[int'(winner)*W +: W];
                mul_start_d = 1'b1;
                state_d     = LAUNCH;
            end
            LAUNCH: begin
                cnt_d   = '0;
                last_d  = owner_q;
                state_d = WAIT;
            end
            WAIT: if (done_rise || cnt_q == CW'(TIMEOUT-1)) begin
                rsp_product_d = done_rise ? mul_product : '0;
                rsp_valid_d   = NREQ'(1) << owner_q;
                rsp_err_d     = ~done_rise;
                state_d       = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            last_q        <= LW'(NREQ-1);
            cnt_q         <= '0;
            done_q        <= 1'b0;
            ack_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_err_q     <= 1'b0;
            mul_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            rsp_product_q <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            done_q        <= mul_done;
            ack_q         <= ack_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            mul_start_q   <= mul_start_d;
            busy_q        <= state_d != IDLE;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            rsp_product_q <= rsp_product_d;
        end
    end

    assign ack         = ack_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_product = rsp_product_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign mul_start   = mul_start_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed stimulus against a stub multiplier with a queue scoreboard.
module tb_mul_arbiter;
    logic clk = 0, rst = 1;
    logic [3:0] req = 0;
    logic [4*257-1:0] op_a = 0, op_b = 0;
    logic [3:0] ack, rsp_valid;
    logic [513:0] rsp_product, mul_product;
    logic rsp_err, busy, mul_start, mul_done;
    logic [256:0] mul_a, mul_b;

    mul_arbiter #(.NREQ(4), .W(257), .PW(514), .TIMEOUT(16), .CW(5)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .ack(ack),
        .rsp_valid(rsp_valid), .rsp_product(rsp_product), .rsp_err(rsp_err), .busy(busy),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_product(mul_product), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0, starts = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mul_start) starts <= starts + 1;

    // stub multiplier: mode 0 raises done lat edges after sampling start; mode 2 holds done high
    int mode = 0, lat = 3, sk = 0;
    logic [513:0] sprod = 0;
    logic sdone = 0, srun = 0;
    always @(posedge clk) begin
        if (mul_start) begin
            sk <= 0;
            srun <= (mode == 0);
            sprod <= {257'b0, mul_a} * {257'b0, mul_b};
            if (mode == 0) sdone <= 1'b0;
        end else if (srun) begin
            sk <= sk + 1;
            if (sk == lat - 1) begin
                sdone <= 1'b1;
                srun <= 1'b0;
            end
        end else if (mode != 0) sdone <= 1'b1;
    end
    assign mul_product = sprod;
    assign mul_done = sdone;

    typedef struct {logic [3:0] vld; logic [513:0] prod; logic err; int cyc;} exp_t;
    exp_t sb[$];
    exp_t e;

    task automatic chk(input string nm, input logic [513:0] act, input logic [513:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [513:0] p, input logic err, input int c);
        sb.push_back('{vld: 4'(1 << i), prod: p, err: err, cyc: c});
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid != 0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp got valid=%b want none", rsp_valid);
            end else begin
                e = sb.pop_front();
                chk("rsp_valid", rsp_valid, e.vld);
                chk("rsp_product", rsp_product, e.prod);
                chk("rsp_err", rsp_err, e.err);
                if (e.cyc >= 0) chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic set_op(input int i, input logic [256:0] a, input logic [256:0] b);
        op_a[i*257 +: 257] = a;
        op_b[i*257 +: 257] = b;
    endtask

    task automatic issue(input int i, input logic [256:0] a, input logic [256:0] b,
                         input logic [513:0] p, input logic err, input int dly);
        int n = 0;
        @(negedge clk);
        set_op(i, a, b);
        push(i, p, err, dly < 0 ? -1 : cyc + 1 + dly);
        req[i] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[i] && n < 50);
        chk("ack_seen", ack[i], 1);
        req[i] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic contend(input logic [3:0] r, input int ord [3], input int ng);
        int g = 0, n = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) if (r[i]) set_op(i, 257'(i + 2), 257'd10);
        for (int j = 0; j < ng; j++) push(ord[j], 514'((ord[j] + 2) * 10), 1'b0, -1);
        req = r;
        while (req != 0 && n < 300) begin
            @(negedge clk);
            n++;
            if (ack != 0) begin
                chk($sformatf("grant%0d", g), ack, g < ng ? 4'(1 << ord[g]) : 4'b0);
                g++;
                req &= ~ack;
            end
        end
        chk("grant_count", g, ng);
        req = 0;
        drain();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ack"}, ack, 0);
        chk({nm, "_rsp_valid"}, rsp_valid, 0);
        chk({nm, "_rsp_product"}, rsp_product, 0);
        chk({nm, "_rsp_err"}, rsp_err, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_mul_a"}, mul_a, 0);
        chk({nm, "_mul_b"}, mul_b, 0);
        chk({nm, "_mul_start"}, mul_start, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int s0, n;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 0;
        // single op with exact ack/start timing
        @(negedge clk);
        set_op(0, 257'd3, 257'd5);
        push(0, 514'd15, 1'b0, cyc + 1 + lat + 2);
        s0 = starts;
        req[0] = 1'b1;
        @(negedge clk);
        chk("single_ack", ack, 4'b0001);
        chk("single_start", mul_start, 1);
        chk("single_busy", busy, 1);
        chk("single_mul_a", mul_a, 3);
        req[0] = 1'b0;
        @(negedge clk);
        chk("single_ack_clr", ack, 0);
        chk("single_start_clr", mul_start, 0);
        drain();
        chk("single_start_count", starts - s0, 1);
        // boundary operands 2^256 * 2^256
        issue(1, 257'b1 << 256, 257'b1 << 256, 514'b1 << 512, 1'b0, lat + 2);
        drain();
        // fresh pointer so requester 0 has first priority again
        rst = 1;
        @(negedge clk);
        rst = 0;
        contend(4'b0111, '{0, 1, 2}, 3);
        contend(4'b1001, '{3, 0, 0}, 2);
        // watchdog with done2 stuck high
        mode = 2;
        repeat (3) @(negedge clk);
        issue(1, 257'd4, 257'd4, 514'd0, 1'b1, 17);
        n = 0;
        while (rsp_valid == 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wd_busy_low", busy, 0);
        drain();
        // stale done2 still high from the watchdog case; only the fresh rise counts
        mode = 0;
        lat = 8;
        issue(0, 257'd6, 257'd7, 514'd42, 1'b0, 10);
        drain();
        // reset in WAIT abandons the operation silently
        lat = 10;
        @(negedge clk);
        set_op(1, 257'd11, 257'd13);
        req[1] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[1] && n < 50);
        req[1] = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", busy, 1);
        #2 rst = 1;
        #1 chk_zero("abort");
        @(negedge clk);
        rst = 0;
        repeat (20) @(negedge clk);
        issue(2, 257'd7, 257'd9, 514'd63, 1'b0, lat + 2);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
